// File: rtl/ntr_pkg.sv
// ntr_pkg: opcodes, command field offsets and responder state encoding.
// This package is shared by the NTR command-capture stage and the responder.
package ntr_pkg;

  localparam logic [7:0] OP_HEADER  = 8'h00;
  localparam logic [7:0] OP_READ    = 8'hB7;
  localparam logic [7:0] OP_CHIPID1 = 8'h90;
  localparam logic [7:0] OP_CHIPID2 = 8'hB8;
  localparam logic [7:0] OP_DUMMY   = 8'h9F;

  // Bit positions of the command fields. The opcode is the first byte on the bus.
  localparam int CMD_OP_MSB   = 63;
  localparam int CMD_OP_LSB   = 56;
  localparam int CMD_ADDR_MSB = 55;
  localparam int CMD_ADDR_LSB = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WAIT_MEM = 3'd3,
    ST_DRIVE    = 3'd4
  } ntr_state_e;

  function automatic logic op_is_mem(input logic [7:0] op);
    return (op == OP_HEADER) || (op == OP_READ);
  endfunction

  // Byte for commands that do not touch memory. Chip-ID bytes go out LSB
  // first and repeat every four bytes. Dummy and unknown opcodes return 0xFF.
  function automatic logic [7:0] synth_byte(input logic [7:0]  op,
                                            input logic [31:0] chip_id,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    b = 8'hFF;
    if ((op == OP_CHIPID1) || (op == OP_CHIPID2)) begin
      b = chip_id[{idx, 3'b000} +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/ntr_cmd_responder_edge_detect.sv
// edge_detect: keeps the previous sample of a signal in a register and
// flags its rising and falling edges. Each flag is high for one cycle.
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Store the previous sample of the signal.
  always_ff @(posedge clk_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/ntr_cmd_responder.sv
// ntr_cmd_responder: decodes a captured NTR command and sends the response
// bytes onto the cartridge bus. Each falling edge of ntr_clk moves to the
// next byte.
// Build option: define NTR_PAGE_WRAP_EN to keep address increments inside
// a 2^PAGE_BITS page.
//
// state    | meaning
// IDLE     | waiting for the rising edge of cmd_ready
// DECODE   | classify the latched opcode
// FETCH    | one-cycle memory read strobe at the current address
// WAIT_MEM | capture mem_rdata into the output byte
// DRIVE    | hold the byte on the bus until the next ntr_clk falling edge
module ntr_cmd_responder
  import ntr_pkg::*;
#(
  parameter logic [31:0] CHIP_ID   = 32'h00001FC2,
  parameter int          PAGE_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ntr_clk,
  input  logic        ntr_cs1,
  input  logic [63:0] command,
  input  logic        cmd_ready,
  output logic [7:0]  ntr_data_out,
  output logic        ntr_data_oe,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  ntr_state_e  state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        oe_q, oe_d;
  logic [31:0] addr_inc;
  logic [31:0] idx_inc;
  logic [7:0]  cmd_op;
  logic        rdy_rise, rdy_fall;
  logic        nclk_rise, nclk_fall;
  logic        unused_bits;

  edge_detect u_rdy_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .sig_i  (cmd_ready),
    .rise_o (rdy_rise),
    .fall_o (rdy_fall)
  );

  edge_detect u_nclk_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .sig_i  (ntr_clk),
    .rise_o (nclk_rise),
    .fall_o (nclk_fall)
  );

  assign unused_bits = ^{command[CMD_ADDR_LSB-1:0], rdy_fall, nclk_rise};
  assign cmd_op      = command[CMD_OP_MSB:CMD_OP_LSB];
  assign idx_inc     = idx_q + 32'd1;

`ifdef NTR_PAGE_WRAP_EN
  // The low PAGE_BITS bits count and wrap; the page number above them stays fixed.
  assign addr_inc = {addr_q[31:PAGE_BITS], addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};
`else
  localparam int unused_page_bits = PAGE_BITS;
  assign addr_inc = addr_q + 32'd1;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 8'h00;
      addr_q  <= 32'h0;
      idx_q   <= 32'h0;
      data_q  <= 8'hFF;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
    end
  end

  // Next-state logic, byte selection and the memory strobe.
  // A high chip select beats every other event, including a falling edge in the same cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oe_d    = oe_q;
    mem_req = 1'b0;
    if (ntr_cs1) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdy_rise) begin
            op_d    = cmd_op;
            addr_d  = (cmd_op == OP_HEADER) ? 32'h0 : command[CMD_ADDR_MSB:CMD_ADDR_LSB];
            idx_d   = 32'h0;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (op_is_mem(op_q)) begin
            state_d = ST_FETCH;
          end else begin
            data_d  = synth_byte(op_q, CHIP_ID, idx_q[1:0]);
            oe_d    = 1'b1;
            state_d = ST_DRIVE;
          end
        end
        ST_FETCH: begin
          mem_req = 1'b1;
          state_d = ST_WAIT_MEM;
        end
        ST_WAIT_MEM: begin
          data_d  = mem_rdata;
          oe_d    = 1'b1;
          state_d = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (nclk_fall) begin
            idx_d  = idx_inc;
            addr_d = addr_inc;
            if (op_is_mem(op_q)) state_d = ST_FETCH;
            else                 data_d  = synth_byte(op_q, CHIP_ID, idx_inc[1:0]);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ntr_data_out = data_q;
  assign ntr_data_oe  = oe_q;
  assign mem_addr     = addr_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ntr_cmd_responder.sv
// tb_ntr_cmd_responder: directed and random command streams for the NTR
// response engine. The bench has its own byte and address model.
// Define NTR_PAGE_WRAP_EN when building with page wrap.
module tb_ntr_cmd_responder;

  localparam logic [31:0] CHIP_ID = 32'h00001FC2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ntr_clk = 1'b1;
  logic        ntr_cs1 = 1'b1;
  logic        cmd_ready = 1'b0;
  logic [63:0] command = 64'h0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  ntr_data_out;
  logic        ntr_data_oe;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        busy;

  int   n_assert = 0;
  int   n_fail = 0;
  int   req_cnt = 0;
  int   consec = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  ntr_cmd_responder dut (
    .clk          (clk),
    .rst          (rst),
    .ntr_clk      (ntr_clk),
    .ntr_cs1      (ntr_cs1),
    .command      (command),
    .cmd_ready    (cmd_ready),
    .ntr_data_out (ntr_data_out),
    .ntr_data_oe  (ntr_data_oe),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  // Backing memory contents, computed from the byte address.
  function automatic logic [7:0] mem_f(input logic [31:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a);
`ifdef NTR_PAGE_WRAP_EN
    return (a & 32'hFFFF_F000) | ((a + 32'd1) & 32'h0000_0FFF);
`else
    return a + 32'd1;
`endif
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == 8'h00) || (op == 8'hB7);
  endfunction

  // Expected byte number k of the response. a is the address for that byte.
  function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [31:0] a, input int k);
    if (is_mem_op(op)) return mem_f(a);
    if ((op == 8'h90) || (op == 8'hB8)) return 8'((CHIP_ID >> (8 * (k % 4))) & 32'hFF);
    return 8'hFF;
  endfunction

  // Memory responder: data is valid one clock after the strobe.
  always @(posedge clk) begin
    if (mem_req) begin
      mem_rdata <= mem_f(mem_addr);
      req_cnt   <= req_cnt + 1;
    end
    if (mem_req && req_prev) consec <= consec + 1;
    req_prev <= mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // End any current transaction, then present a new command.
  task automatic start_cmd(input logic [7:0] op, input logic [31:0] addr);
    ntr_cs1   = 1'b1;
    cmd_ready = 1'b0;
    ntr_clk   = 1'b1;
    tick();
    tick();
    command   = {op, addr, 24'h0};
    ntr_cs1   = 1'b0;
    cmd_ready = 1'b1;
  endtask

  // One full transaction: first-byte latency, then nf falling edges.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input int nf);
    logic [31:0] a;
    logic [7:0]  prev;
    int          r0;
    logic        mem;
    mem = is_mem_op(op);
    a   = (op == 8'h00) ? 32'h0 : addr;
    start_cmd(op, addr);
    r0 = req_cnt;
    tick();
    chk("oe_low_decode", {31'h0, ntr_data_oe}, 32'h0);
    chk("busy_decode", {31'h0, busy}, 32'h1);
    if (mem) begin
      tick();
      chk("first_req", {31'h0, mem_req}, 32'h1);
      chk("first_addr", mem_addr, a);
      tick();
      chk("oe_low_wait", {31'h0, ntr_data_oe}, 32'h0);
      tick();
    end else begin
      tick();
      tick();
    end
    chk("first_byte", {24'h0, ntr_data_out}, {24'h0, exp_byte(op, a, 0)});
    chk("first_oe", {31'h0, ntr_data_oe}, 32'h1);
    for (int k = 1; k <= nf; k++) begin
      prev    = exp_byte(op, a, k - 1);
      a       = next_addr(a);
      ntr_clk = 1'b0;
      if (mem) begin
        tick();
        chk("fall_req", {31'h0, mem_req}, 32'h1);
        chk("fall_addr", mem_addr, a);
        tick();
        chk("byte_hold", {24'h0, ntr_data_out}, {24'h0, prev});
        tick();
        chk("mem_byte", {24'h0, ntr_data_out}, {24'h0, exp_byte(op, a, k)});
        tick();
      end else begin
        tick();
        chk("synth_byte", {24'h0, ntr_data_out}, {24'h0, exp_byte(op, a, k)});
        tick();
        tick();
        tick();
      end
      chk("oe_stream", {31'h0, ntr_data_oe}, 32'h1);
      ntr_clk = 1'b1;
      for (int j = 0; j < 4; j++) tick();
    end
    chk("req_count", req_cnt - r0, mem ? (nf + 1) : 0);
    chk("no_back_to_back_req", consec, 0);
  endtask

  initial begin
    logic [7:0] op;
    int         c0;
    tick();
    tick();
    chk("rst_data", {24'h0, ntr_data_out}, 32'hFF);
    chk("rst_oe", {31'h0, ntr_data_oe}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'h0, busy}, 32'h0);

    run_cmd(8'hB7, 32'h00001234, 3);
    run_cmd(8'h90, $urandom, 6);
    run_cmd(8'h9F, $urandom, 2);
    run_cmd(8'h3C, $urandom, 2);
    run_cmd(8'h00, $urandom, 2);

    run_cmd(8'hB7, 32'h00001FFF, 1);
`ifdef NTR_PAGE_WRAP_EN
    chk("page_wrap", mem_addr, 32'h00001000);
`else
    chk("page_wrap", mem_addr, 32'h00002000);
`endif
    run_cmd(8'hB7, 32'hFFFFFFFF, 1);
`ifdef NTR_PAGE_WRAP_EN
    chk("top_wrap", mem_addr, 32'hFFFFF000);
`else
    chk("top_wrap", mem_addr, 32'h00000000);
`endif

    // Chip select rises while a memory read is in flight.
    start_cmd(8'hB7, 32'h00000100);
    tick();
    tick();
    tick();
    chk("wait_busy", {31'h0, busy}, 32'h1);
    c0 = req_cnt;
    ntr_cs1 = 1'b1;
    tick();
    chk("cs_wait_busy", {31'h0, busy}, 32'h0);
    chk("cs_wait_oe", {31'h0, ntr_data_oe}, 32'h0);
    chk("cs_wait_req", {31'h0, mem_req}, 32'h0);
    tick();
    tick();
    chk("cs_wait_no_req", req_cnt - c0, 0);

    // Chip select rises in the same cycle as a falling edge while driving a byte.
    start_cmd(8'hB7, 32'h00000200);
    for (int j = 0; j < 4; j++) tick();
    chk("drive_oe", {31'h0, ntr_data_oe}, 32'h1);
    c0 = req_cnt;
    ntr_clk = 1'b0;
    ntr_cs1 = 1'b1;
    tick();
    chk("cs_fall_busy", {31'h0, busy}, 32'h0);
    chk("cs_fall_oe", {31'h0, ntr_data_oe}, 32'h0);
    chk("cs_fall_req", {31'h0, mem_req}, 32'h0);
    tick();
    tick();
    chk("cs_fall_no_req", req_cnt - c0, 0);

    // Reset while a byte is being driven.
    start_cmd(8'hB8, 32'h0000ABCD);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_data", {24'h0, ntr_data_out}, 32'hFF);
    chk("mid_rst_oe", {31'h0, ntr_data_oe}, 32'h0);
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    ntr_cs1   = 1'b1;
    cmd_ready = 1'b0;
    rst       = 1'b0;
    run_cmd(8'hB7, 32'h00000040, 2);

    // Random commands.
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 5))
        0:       op = 8'h00;
        1:       op = 8'hB7;
        2:       op = 8'h90;
        3:       op = 8'hB8;
        4:       op = 8'h9F;
        default: op = 8'($urandom);
      endcase
      run_cmd(op, $urandom, $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
